// File: rtl/spi_frame_loader_pkg.sv
// ============================================================================
// Module : spi_frame_loader_pkg
// Brief  : Shared FSM state encoding and retry timeout for spi_frame_loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_frame_loader_pkg;

   localparam logic [1:0] c_ST_IDLE      = 2'd0;
   localparam logic [1:0] c_ST_LOAD      = 2'd1;
   localparam logic [1:0] c_ST_WAIT_LOW  = 2'd2;
   localparam logic [1:0] c_ST_WAIT_HIGH = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = c_ST_IDLE,
      LOAD      = c_ST_LOAD,
      WAIT_LOW  = c_ST_WAIT_LOW,
      WAIT_HIGH = c_ST_WAIT_HIGH
   } state_t;

   // Cycles spent in WAIT_LOW with cs still high before start is re-pulsed.
   localparam logic [2:0] c_TIMEOUT = 3'd4;

endpackage : spi_frame_loader_pkg

`default_nettype wire

// File: rtl/spi_frame_loader.sv
// ============================================================================
// Module : spi_frame_loader
// Brief  : One-deep word buffer that loads frames into an SPI master and
//          sequences start/done around the master's chip-select.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_loader
   import spi_frame_loader_pkg::*;
#(
   parameter int BITS      = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BITS-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            spi_cs,
   output logic [BITS-1:0] out_buf,
   output logic            start,
   output logic            done,
   output logic            busy
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BITS-1:0] r_pend_data;
   logic            r_pend_valid;
   logic [BITS-1:0] r_out_buf;
   logic            r_start;
   logic            r_done;
   logic [2:0]      r_cnt;
   logic            w_accept;
   logic            w_enter_load;
   logic            w_launch;
   logic            w_frame_end;
   logic [BITS-1:0] w_frame;

   function automatic logic [BITS-1:0] f_reverse(input logic [BITS-1:0] d);
      logic [BITS-1:0] r;
      for (int i = 0; i < BITS; i++) begin
         r[i] = d[BITS-1-i];
      end
      return r;
   endfunction

   assign in_ready = !r_pend_valid;
   assign w_accept = in_valid && in_ready;
   assign w_frame  = MSB_FIRST ? f_reverse(r_pend_data) : r_pend_data;

   always_comb begin
      w_state_nxt  = r_state;
      w_frame_end  = 1'b0;
      case (r_state)
         IDLE: begin
            // A low cs here belongs to someone else's transaction; hold off.
            if (r_pend_valid && spi_cs) begin
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            w_state_nxt = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!spi_cs) begin
               w_state_nxt = WAIT_HIGH;
            end else if (r_cnt == c_TIMEOUT - 3'd1) begin
               w_state_nxt = LOAD;
            end
         end
         WAIT_HIGH: begin
            if (spi_cs) begin
               w_state_nxt = IDLE;
               w_frame_end = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_enter_load = (w_state_nxt == LOAD);
   assign w_launch     = (r_state == IDLE) && w_enter_load;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_pend_data  <= '0;
         r_pend_valid <= 1'b0;
         r_out_buf    <= '0;
         r_start      <= 1'b0;
         r_done       <= 1'b0;
         r_cnt        <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_start <= w_enter_load;
         r_done  <= w_frame_end;

         if (w_enter_load) begin
            r_cnt <= 3'd0;
         end else if (r_state == WAIT_LOW) begin
            r_cnt <= r_cnt + 3'd1;
         end

         // Retries re-enter LOAD from WAIT_LOW and keep the frame untouched.
         if (w_launch) begin
            r_out_buf <= w_frame;
         end

         if (w_accept) begin
            r_pend_data  <= in_data;
            r_pend_valid <= 1'b1;
         end else if (w_launch) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   assign out_buf = r_out_buf;
   assign start   = r_start;
   assign done    = r_done;
   assign busy    = (r_state != IDLE);

endmodule : spi_frame_loader

`default_nettype wire

// File: tb/tb_spi_frame_loader.sv
// ============================================================================
// Module : tb_spi_frame_loader
// Brief  : Directed bench for spi_frame_loader (MSB_FIRST=1 and =0 copies).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_data;
   logic       in_valid;
   logic       spi_cs;

   logic       in_ready, start, done, busy;
   logic [3:0] out_buf;
   logic       l_in_ready, l_start, l_done, l_busy;
   logic [3:0] l_out_buf;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   spi_frame_loader #(.BITS(4), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .spi_cs(spi_cs), .out_buf(out_buf),
      .start(start), .done(done), .busy(busy)
   );

   spi_frame_loader #(.BITS(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(l_in_ready), .spi_cs(spi_cs), .out_buf(l_out_buf),
      .start(l_start), .done(l_done), .busy(l_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
      if (done) done_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; in_data = 4'h0; in_valid = 1'b0; spi_cs = 1'b1;
      step(); step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_buf", 32'(out_buf), 32'h0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_lsb_all", {27'd0, l_busy, l_in_ready, l_start, l_done, 1'b0}, 32'h8);
      chk("rst_lsb_buf", 32'(l_out_buf), 32'h0);
      reset = 1'b0;
      step();

      // Basic launch: accept 0001, start two cycles later, out_buf reversed.
      in_data = 4'b0001; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_in_ready_pend", 32'(in_ready), 32'd0);
      chk("t1_start_early", 32'(start), 32'd0);
      step();
      chk("t1_start", 32'(start), 32'd1);
      chk("t1_out_buf", 32'(out_buf), 32'h8);
      chk("t1_lsb_out_buf", 32'(l_out_buf), 32'h1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_in_ready_free", 32'(in_ready), 32'd1);
      step();
      chk("t1_start_width", 32'(start), 32'd0);
      spi_cs = 1'b0;
      step();
      chk("t1_wait_high_busy", 32'(busy), 32'd1);
      chk("t1_no_done_yet", 32'(done), 32'd0);
      spi_cs = 1'b1;
      step();
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_idle", 32'(busy), 32'd0);
      step();
      chk("t1_done_width", 32'(done), 32'd0);

      // Back-to-back A then 5: second word waits in the pending register.
      done_cnt = 0;
      in_data = 4'hA; in_valid = 1'b1;
      step();
      in_data = 4'h5;
      chk("t2_ready_low", 32'(in_ready), 32'd0);
      step();
      chk("t2_start_a", 32'(start), 32'd1);
      chk("t2_out_buf_a", 32'(out_buf), 32'h5);
      chk("t2_ready_again", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("t2_pend_5", 32'(in_ready), 32'd0);
      chk("t2_start_off", 32'(start), 32'd0);
      spi_cs = 1'b0;
      step();
      chk("t2_hold_ready", 32'(in_ready), 32'd0);
      chk("t2_hold_buf", 32'(out_buf), 32'h5);
      spi_cs = 1'b1;
      step();
      chk("t2_done_a", 32'(done), 32'd1);
      chk("t2_idle_a", 32'(busy), 32'd0);
      step();
      chk("t2_start_5", 32'(start), 32'd1);
      chk("t2_out_buf_5", 32'(out_buf), 32'hA);
      chk("t2_done_width", 32'(done), 32'd0);
      step();
      spi_cs = 1'b0;
      step();
      spi_cs = 1'b1;
      step();
      chk("t2_done_5", 32'(done), 32'd1);
      step();
      chk("t2_idle_end", 32'(busy), 32'd0);
      chk("t2_done_count", 32'(done_cnt), 32'd2);

      // Foreign transaction: cs low while idle blocks the launch.
      spi_cs = 1'b0;
      in_data = 4'b0011; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("t3_no_start_a", 32'(start), 32'd0);
      chk("t3_idle_a", 32'(busy), 32'd0);
      step();
      chk("t3_no_start_b", 32'(start), 32'd0);
      spi_cs = 1'b1;
      step();
      chk("t3_start", 32'(start), 32'd1);
      chk("t3_out_buf", 32'(out_buf), 32'hC);
      chk("t3_lsb_out_buf", 32'(l_out_buf), 32'h3);
      chk("t3_lsb_start", 32'(l_start), 32'd1);
      step();
      spi_cs = 1'b0;
      step();
      spi_cs = 1'b1;
      step();
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_lsb_done", 32'(l_done), 32'd1);

      // Retry: cs never drops, start re-pulses five cycles after the first.
      in_data = 4'b0110; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("t4_start_first", 32'(start), 32'd1);
      chk("t4_out_buf", 32'(out_buf), 32'h6);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("t4_gap_%0d", i), {30'd0, start, busy}, 32'h1);
      end
      step();
      chk("t4_start_retry", 32'(start), 32'd1);
      chk("t4_out_buf_kept", 32'(out_buf), 32'h6);
      step();
      chk("t4_retry_width", 32'(start), 32'd0);
      spi_cs = 1'b0;
      step();

      // Reset in WAIT_HIGH with a word pending: frame and word both dropped.
      in_data = 4'h9; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t5_pending", 32'(in_ready), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_ready", 32'(in_ready), 32'd1);
      chk("t5_rst_buf", 32'(out_buf), 32'h0);
      chk("t5_rst_done", 32'(done), 32'd0);
      reset = 1'b0; spi_cs = 1'b1;
      step();
      chk("t5_no_done", 32'(done), 32'd0);
      chk("t5_no_start", 32'(start), 32'd0);
      step();
      chk("t5_still_idle", {30'd0, start, busy}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_spi_frame_loader

`default_nettype wire
